// File: rtl/pkg_estacionamento.sv
// rtl/pkg_estacionamento.sv - shared exit-gate states, display codes and timing defaults
package pkg_estacionamento;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LIBERADO = 2'd1,
    PASSANDO = 2'd2,
    ERRO     = 2'd3
  } estado_t;

  // Bit positions inside the one-hot frase display code
  localparam int FRASE_ERRO     = 3;
  localparam int FRASE_LIBERADO = 2;
  localparam int FRASE_PARE     = 1;
  localparam int FRASE_CHEIO    = 0;
  localparam int LARGURA_FRASE  = 4;

  localparam int TEMPO_LIMITE_PADRAO = 20;

  // One-hot display word with only the given message bit set
  function automatic logic [LARGURA_FRASE-1:0] frase_codigo(input int indice);
    logic [LARGURA_FRASE-1:0] codigo;
    codigo = '0;
    codigo[indice] = 1'b1;
    return codigo;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// rtl/sincronizador.sv - two-flop synchronizer for an asynchronous sensor level
module sincronizador (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/controle_de_saida.sv
// rtl/controle_de_saida.sv - parking exit gate controller with occupancy counter
module controle_de_saida
  import pkg_estacionamento::*;
#(
  parameter int CAPACIDADE   = 8,
  parameter int LARGURA      = 4,
  parameter int TEMPO_LIMITE = TEMPO_LIMITE_PADRAO
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_1hz,
  input  logic                     sensor_interno,
  input  logic                     sensor_externo,
  input  logic                     entrada_confirmada,
  output logic                     cancela_saida,
  output logic [LARGURA_FRASE-1:0] frase,
  output logic                     cheio,
  output logic [LARGURA-1:0]       ocupacao
);

  localparam int                    LARG_TEMPO = $clog2(TEMPO_LIMITE + 1);
  localparam logic [LARGURA-1:0]    CAP        = LARGURA'(CAPACIDADE);
  localparam logic [LARG_TEMPO-1:0] LIMITE     = LARG_TEMPO'(TEMPO_LIMITE);

  logic si;
  logic se;

  estado_t                  estado_q;
  logic                     cancela_q;
  logic [LARGURA_FRASE-1:0] frase_q;
  logic [LARG_TEMPO-1:0]    timer_q;
  logic [LARGURA-1:0]       ocupacao_q;
  logic [LARGURA-1:0]       ocupacao_d;
  logic                     pedido_saida;
  logic                     entra_liberado;
  logic [LARGURA_FRASE-1:0] frase_ocioso;

  sincronizador u_sinc_interno (
    .clk   (clk),
    .reset (reset),
    .d_i   (sensor_interno),
    .q_o   (si)
  );

  sincronizador u_sinc_externo (
    .clk   (clk),
    .reset (reset),
    .d_i   (sensor_externo),
    .q_o   (se)
  );

  // The vehicle has cleared both sensors: the same edge leaves PASSANDO and decrements
  assign pedido_saida   = (estado_q == PASSANDO) && !si && !se;
  assign entra_liberado = (estado_q == OCIOSO) && si && !se;

  // Next occupancy: simultaneous entry and exit cancel out, no wrap at either end
  always_comb begin
    ocupacao_d = ocupacao_q;
    if (entrada_confirmada && !pedido_saida) begin
      if (ocupacao_q < CAP) ocupacao_d = ocupacao_q + 1'b1;
    end else if (pedido_saida && !entrada_confirmada) begin
      if (ocupacao_q != '0) ocupacao_d = ocupacao_q - 1'b1;
    end
  end

  // Idle display uses the next occupancy so CHEIO lines up with the cheio output
  assign frase_ocioso = (ocupacao_d == CAP) ? frase_codigo(FRASE_CHEIO) : '0;

  // Occupancy register; reset drops any exit still in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ocupacao_q <= '0;
    else       ocupacao_q <= ocupacao_d;
  end

  // Seconds counter: restarts when the gate opens, stops at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             timer_q <= '0;
    else if (entra_liberado)               timer_q <= '0;
    else if (tick_1hz && timer_q != LIMITE) timer_q <= timer_q + 1'b1;
  end

  // Exit FSM with gate and display registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      cancela_q <= 1'b0;
      frase_q   <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (si && se) begin
            estado_q  <= ERRO;
            cancela_q <= 1'b0;
            frase_q   <= frase_codigo(FRASE_ERRO);
          end else if (si) begin
            estado_q  <= LIBERADO;
            cancela_q <= 1'b1;
            frase_q   <= frase_codigo(FRASE_LIBERADO);
          end else begin
            cancela_q <= 1'b0;
            frase_q   <= frase_ocioso;
          end
        end
        LIBERADO: begin
          if (se) begin
            estado_q  <= PASSANDO;
            cancela_q <= 1'b1;
            frase_q   <= frase_codigo(FRASE_PARE);
          end else if (timer_q == LIMITE) begin
            estado_q  <= ERRO;
            cancela_q <= 1'b0;
            frase_q   <= frase_codigo(FRASE_ERRO);
          end
        end
        PASSANDO: begin
          if (pedido_saida) begin
            estado_q  <= OCIOSO;
            cancela_q <= 1'b0;
            frase_q   <= frase_ocioso;
          end
        end
        ERRO: begin
          if (!si && !se) begin
            estado_q  <= OCIOSO;
            cancela_q <= 1'b0;
            frase_q   <= frase_ocioso;
          end
        end
        default: begin
          estado_q  <= OCIOSO;
          cancela_q <= 1'b0;
          frase_q   <= '0;
        end
      endcase
    end
  end

  assign cancela_saida = cancela_q;
  assign frase         = frase_q;
  assign ocupacao      = ocupacao_q;
  assign cheio         = (ocupacao_q == CAP);

endmodule
